// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings, FSM state type and access-size helper for
//               the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Store width encodings carried on we*/mem_we
  localparam logic [1:0] c_we_none = 2'd0;
  localparam logic [1:0] c_we_sb   = 2'd1;
  localparam logic [1:0] c_we_sh   = 2'd2;
  localparam logic [1:0] c_we_sw   = 2'd3;

  // Load type encodings carried on re*/mem_re (6 and 7 are illegal)
  localparam logic [2:0] c_re_none = 3'd0;
  localparam logic [2:0] c_re_lb   = 3'd1;
  localparam logic [2:0] c_re_lh   = 3'd2;
  localparam logic [2:0] c_re_lw   = 3'd3;
  localparam logic [2:0] c_re_lbu  = 3'd4;
  localparam logic [2:0] c_re_lhu  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Number of bytes touched by an access; 0 for a no-op. A store width takes
  // precedence when both fields are set (such requests are errors anyway).
  function automatic logic [2:0] access_size(input logic [1:0] we, input logic [2:0] re);
    logic [2:0] size;
    size = 3'd0;
    case (we)
      c_we_sb: size = 3'd1;
      c_we_sh: size = 3'd2;
      c_we_sw: size = 3'd4;
      default: begin
        case (re)
          c_re_lb, c_re_lbu: size = 3'd1;
          c_re_lh, c_re_lhu: size = 3'd2;
          c_re_lw:           size = 3'd4;
          default:           size = 3'd0;
        endcase
      end
    endcase
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with a port-1 ownership lock.
//               Grants are combinational; the last-served port is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_lock1,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // High when port 1 won the most recent grant; cleared so port 1 wins the
  // first tie after reset.
  logic r_last1;

  // Port 0 wins a tie only when port 1 was served last, and never while port 1
  // holds the lock after being served.
  always_comb begin
    o_gnt0 = i_en & i_req0 & ~(i_lock1 & r_last1) & (~i_req1 | r_last1);
    o_gnt1 = i_en & i_req1 & ~o_gnt0;
  end

  // Remember which port was served on every accepted grant.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last1 <= 1'b0;
    end else if (o_gnt0 | o_gnt1) begin
      r_last1 <= o_gnt1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates two request ports onto a single data memory.
//               IDLE/RESP accept, ISSUE drives the memory for one cycle,
//               RESP returns a one-cycle rvalid to the owning port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        we0,
  input  logic [1:0]        we1,
  input  logic [2:0]        re0,
  input  logic [2:0]        re1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_we,
  output logic [2:0]        mem_re,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W:0] c_mem_bytes = (ADDR_W+1)'(MEM_BYTES);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_en;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_we;
  logic [2:0]        w_re;
  logic [2:0]        w_size;
  logic [ADDR_W:0]   w_end;
  logic              w_err;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_we;
  logic [2:0]        r_re;
  logic              r_port;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  // Grants are only offered in accepting states and never while reset is held.
  assign w_en     = reset & ((r_state == ST_IDLE) || (r_state == ST_RESP));
  assign w_accept = gnt0 | gnt1;

  rr_arb2 u_arb (
    .clk     (clk),
    .i_rst_n (reset),
    .i_en    (w_en),
    .i_lock1 (lock1),
    .i_req0  (req0),
    .i_req1  (req1),
    .o_gnt0  (gnt0),
    .o_gnt1  (gnt1)
  );

  // Select the granted request and classify it as legal or erroneous.
  always_comb begin
    w_addr  = gnt1 ? addr1  : addr0;
    w_wdata = gnt1 ? wdata1 : wdata0;
    w_we    = gnt1 ? we1    : we0;
    w_re    = gnt1 ? re1    : re0;
    w_size  = access_size(w_we, w_re);
    w_end   = {1'b0, w_addr} + (ADDR_W+1)'(w_size);
    w_err   = 1'b0;
    if ((w_we != c_we_none) && (w_re != c_re_none)) w_err = 1'b1;
    if (w_re > c_re_lhu)                            w_err = 1'b1;
    if (w_end > c_mem_bytes)                        w_err = 1'b1;
    if ((w_size == 3'd2) && w_addr[0])              w_err = 1'b1;
    if ((w_size == 3'd4) && (w_addr[1:0] != 2'b00)) w_err = 1'b1;
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus all state-decoded outputs. Memory strobes are decoded from
  // the state so an asynchronous reset removes a pending store immediately.
  always_comb begin
    w_state_nxt = r_state;
    mem_we      = c_we_none;
    mem_re      = c_re_none;
    rvalid0     = 1'b0;
    rvalid1     = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    rdata0      = '0;
    rdata1      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RESP;
        if (!r_err) begin
          mem_we = r_we;
          mem_re = r_re;
        end
      end
      ST_RESP: begin
        w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
        if (r_port) begin
          rvalid1 = 1'b1;
          err1    = r_err;
          rdata1  = r_rdata;
        end else begin
          rvalid0 = 1'b1;
          err0    = r_err;
          rdata0  = r_rdata;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the accepted request, then the memory's read data during ISSUE.
  // Stores, no-ops and errors answer with zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= c_we_none;
      r_re    <= c_re_none;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_we    <= w_we;
        r_re    <= w_re;
        r_port  <= gnt1;
        r_err   <= w_err;
      end
      if (r_state == ST_ISSUE) begin
        r_rdata <= (r_err || (r_we != c_we_none) || (r_re == c_re_none)) ? '0 : mem_data_out;
      end
    end
  end

  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomised and directed scoreboard bench for dmem_arbiter,
//               with a byte-array memory model driven by mem_* signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_BYTES = 1024;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  we;
    logic [2:0]  re;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  we0 = '0, we1 = '0;
  logic [2:0]  re0 = '0, re1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1, mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_we;
  logic [2:0]  mem_re;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lock_phase = 1'b0;

  logic [7:0] phys    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  bit         phys_loaded = 1'b0;
  bit         ref_loaded  = 1'b0;

  txn_t q0[$];
  txn_t q1[$];
  txn_t acc;
  int   acc_cyc = -10;
  int   acc_port_log[$];
  int   acc_cyc_log[$];
  rsp_t rsp_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1), .re0(re0), .re1(re1),
    .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_re(mem_re), .mem_data_out(mem_data_out)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Load result from a little-endian 32-bit window starting at the address.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] re);
    case (re)
      3'd1:    return {{24{raw[7]}}, raw[7:0]};
      3'd2:    return {{16{raw[15]}}, raw[15:0]};
      3'd3:    return raw;
      3'd4:    return {24'h0, raw[7:0]};
      3'd5:    return {16'h0, raw[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] w, input logic [2:0] r);
    logic [63:0] sz;
    if (w != 0 && r != 0) return 1'b1;
    if (r > 5) return 1'b1;
    if (w == 1 || r == 1 || r == 4)      sz = 1;
    else if (w == 2 || r == 2 || r == 5) sz = 2;
    else if (w == 3 || r == 3)           sz = 4;
    else                                 sz = 0;
    if ({32'h0, a} + sz > 64'(MEM_BYTES)) return 1'b1;
    if (sz != 0 && ({32'h0, a} % sz) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: combinational read, write on the clock edge.
  always_comb begin
    logic [9:0] a;
    a = mem_address[9:0];
    mem_data_out = 32'h0;
    if (mem_re != 3'd0)
      mem_data_out = extend({phys[a + 10'd3], phys[a + 10'd2], phys[a + 10'd1], phys[a]}, mem_re);
  end

  always @(posedge clk) begin
    if (!phys_loaded) begin
      for (int i = 0; i < MEM_BYTES; i++) phys[i] <= init_byte(i);
      phys_loaded <= 1'b1;
    end else if (mem_we != 2'd0) begin
      phys[mem_address[9:0]] <= mem_data_in[7:0];
      if (mem_we >= 2'd2) phys[mem_address[9:0] + 10'd1] <= mem_data_in[15:8];
      if (mem_we == 2'd3) begin
        phys[mem_address[9:0] + 10'd2] <= mem_data_in[23:16];
        phys[mem_address[9:0] + 10'd3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic accept(input int p);
    txn_t t;
    logic [9:0] a;
    t.cyc   = cyc;
    t.addr  = (p == 0) ? addr0 : addr1;
    t.wdata = (p == 0) ? wdata0 : wdata1;
    t.we    = (p == 0) ? we0 : we1;
    t.re    = (p == 0) ? re0 : re1;
    t.err   = ref_err(t.addr, t.we, t.re);
    a       = t.addr[9:0];
    t.rdata = 32'h0;
    if (!t.err && t.we == 0 && t.re != 0)
      t.rdata = extend({ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]}, t.re);
    if (p == 0) q0.push_back(t); else q1.push_back(t);
    acc     = t;
    acc_cyc = cyc;
    acc_port_log.push_back(p);
    acc_cyc_log.push_back(cyc);
  endtask

  // Monitor: responses, memory strobes and accepts, sampled mid-cycle.
  always @(negedge clk) begin
    txn_t        e;
    logic        v;
    logic        er;
    logic [31:0] rd;
    logic [9:0]  a;
    rsp_t        r;
    if (!ref_loaded) begin
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
      ref_loaded = 1'b1;
    end
    if (!reset) begin
      q0.delete();
      q1.delete();
      acc_cyc = -10;
    end else begin
      chk("gnt_onehot", 32'(gnt0 & gnt1), 32'h0);
      chk("rvalid_overlap", 32'(rvalid0 & rvalid1), 32'h0);
      if (lock_phase && lock1) chk("lock_gnt0", 32'(gnt0), 32'h0);
      for (int p = 0; p < 2; p++) begin
        v  = (p == 0) ? rvalid0 : rvalid1;
        er = (p == 0) ? err0 : err1;
        rd = (p == 0) ? rdata0 : rdata1;
        chk("err_without_rvalid", 32'(er & ~v), 32'h0);
        if (v) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            chk("unexpected_rvalid", 32'(p), 32'hffff_ffff);
          end else begin
            if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk("latency", 32'(cyc - e.cyc), 32'd2);
            chk("rdata", rd, e.rdata);
            chk("err", 32'(er), 32'(e.err));
            r.port = p; r.rdata = rd; r.err = er;
            rsp_log.push_back(r);
            if (!e.err && e.we != 0) begin
              a = e.addr[9:0];
              ref_mem[a] = e.wdata[7:0];
              if (e.we >= 2) ref_mem[a + 10'd1] = e.wdata[15:8];
              if (e.we == 3) begin
                ref_mem[a + 10'd2] = e.wdata[23:16];
                ref_mem[a + 10'd3] = e.wdata[31:24];
              end
            end
          end
        end
      end
      if (cyc == acc_cyc + 1) begin
        chk("issue_mem_we", 32'(mem_we), acc.err ? 32'h0 : 32'(acc.we));
        chk("issue_mem_re", 32'(mem_re), acc.err ? 32'h0 : 32'(acc.re));
        if (!acc.err && (acc.we != 0 || acc.re != 0)) chk("issue_mem_address", mem_address, acc.addr);
        if (!acc.err && acc.we != 0) chk("issue_mem_data_in", mem_data_in, acc.wdata);
      end else begin
        chk("idle_mem_we", 32'(mem_we), 32'h0);
        chk("idle_mem_re", 32'(mem_re), 32'h0);
      end
      if (req0 && gnt0) accept(0);
      if (req1 && gnt1) accept(1);
    end
  end

  task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] w, input logic [2:0] r);
    bit got;
    got = 1'b0;
    if (p == 0) begin addr0 = a; wdata0 = d; we0 = w; re0 = r; req0 = 1'b1; end
    else        begin addr1 = a; wdata1 = d; we1 = w; re1 = r; req1 = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("grant_timeout", 32'(p), 32'hffff_ffff);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rand_req(input int p);
    int          k;
    logic [31:0] a;
    logic [1:0]  w;
    logic [2:0]  r;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    k = $urandom_range(0, 9);
    w = 2'd0;
    r = 3'd0;
    if (k <= 2)      w = 2'(k + 1);
    else if (k <= 7) r = 3'($urandom_range(1, 5));
    else if (k == 9) begin
      if ($urandom_range(0, 1) == 1) begin
        w = 2'($urandom_range(1, 3));
        r = 3'($urandom_range(1, 7));
      end else begin
        r = 3'($urandom_range(6, 7));
      end
    end
    a = 32'($urandom_range(0, MEM_BYTES + 7));
    if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
    if ($urandom_range(0, 15) == 0) a = $urandom;
    do_req(p, a, $urandom, w, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'h0);
    chk("drain_q1", 32'(q1.size()), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int          rel_cyc;
    int          base;
    int          drop_cyc;
    logic [31:0] exp_rd [6];

    // Reset with both ports already requesting: everything must read zero.
    addr0 = 32'd0; re0 = 3'd3; req0 = 1'b1;
    addr1 = 32'd4; re1 = 3'd3; req1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'h0);
    chk("rst_gnt1", 32'(gnt1), 32'h0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'h0);
    chk("rst_err", 32'({err0, err1}), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_mem_strobes", 32'({mem_we, mem_re}), 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);

    // Tie straight out of reset: port 1 first, port 0 in the following RESP.
    @(posedge clk);
    #2;
    reset = 1'b1;
    rel_cyc = cyc;
    base = acc_port_log.size();
    fork
      do_req(0, 32'd0, 32'h0, 2'd0, 3'd3);
      do_req(1, 32'd4, 32'h0, 2'd0, 3'd3);
    join
    drain();
    chk("tie_count", 32'(acc_port_log.size() - base), 32'd2);
    if (acc_port_log.size() >= base + 2) begin
      chk("tie_first_port", 32'(acc_port_log[base]), 32'd1);
      chk("tie_second_port", 32'(acc_port_log[base + 1]), 32'd0);
      chk("grant_after_reset", 32'(acc_cyc_log[base]), 32'(rel_cyc));
      chk("tie_second_gap", 32'(acc_cyc_log[base + 1] - acc_cyc_log[base]), 32'd2);
    end

    // Store word then read it back with every load flavour.
    base = rsp_log.size();
    do_req(0, 32'd8, 32'h8000c0fe, 2'd3, 3'd0);
    do_req(0, 32'd8, 32'h0, 2'd0, 3'd3);
    do_req(0, 32'd8, 32'h0, 2'd0, 3'd1);
    do_req(0, 32'd8, 32'h0, 2'd0, 3'd2);
    do_req(0, 32'd8, 32'h0, 2'd0, 3'd4);
    do_req(0, 32'd8, 32'h0, 2'd0, 3'd5);
    drain();
    exp_rd = '{32'h0, 32'h8000c0fe, 32'hfffffffe, 32'hffffc0fe, 32'h000000fe, 32'h0000c0fe};
    chk("load_rsp_count", 32'(rsp_log.size() - base), 32'd6);
    if (rsp_log.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk("load_rdata", rsp_log[base + i].rdata, exp_rd[i]);

    // Misaligned load and out-of-range store both answer with err.
    base = rsp_log.size();
    do_req(0, 32'd10, 32'h0, 2'd0, 3'd3);
    do_req(1, 32'd1023, 32'h1234, 2'd2, 3'd0);
    drain();
    chk("err_rsp_count", 32'(rsp_log.size() - base), 32'd2);
    if (rsp_log.size() >= base + 2)
      for (int i = 0; i < 2; i++) begin
        chk("err_flag", 32'(rsp_log[base + i].err), 32'd1);
        chk("err_rdata", rsp_log[base + i].rdata, 32'h0);
      end

    // Lock: port 1 keeps ownership for three requests while port 0 waits.
    do_req(0, 32'd0, 32'h0, 2'd0, 3'd3);
    drain();
    base = acc_port_log.size();
    drop_cyc = 0;
    lock1 = 1'b1;
    lock_phase = 1'b1;
    fork
      do_req(0, 32'd12, 32'h0, 2'd0, 3'd3);
      begin
        do_req(1, 32'd16, 32'h0, 2'd0, 3'd3);
        do_req(1, 32'd20, 32'h0, 2'd0, 3'd3);
        do_req(1, 32'd24, 32'h0, 2'd0, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        lock1 = 1'b0;
        drop_cyc = cyc;
      end
    join
    lock_phase = 1'b0;
    drain();
    chk("lock_accept_count", 32'(acc_port_log.size() - base), 32'd4);
    if (acc_port_log.size() >= base + 4) begin
      for (int i = 0; i < 3; i++) chk("lock_port1_first", 32'(acc_port_log[base + i]), 32'd1);
      chk("lock_port0_last", 32'(acc_port_log[base + 3]), 32'd0);
      chk("lock_port0_after_drop", 32'(acc_cyc_log[base + 3] >= drop_cyc), 32'd1);
      chk("lock_back_to_back", 32'(acc_cyc_log[base + 2] - acc_cyc_log[base]), 32'd4);
    end

    // Reset during ISSUE of a store: the store must not reach memory.
    do_req(0, 32'd32, 32'hdeadbeef, 2'd3, 3'd0);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    base = rsp_log.size();
    do_req(0, 32'd32, 32'h0, 2'd0, 3'd3);
    drain();
    chk("reset_rsp_count", 32'(rsp_log.size() - base), 32'd1);
    if (rsp_log.size() >= base + 1)
      chk("reset_old_value", rsp_log[base].rdata,
          {init_byte(35), init_byte(34), init_byte(33), init_byte(32)});

    // Random traffic from both ports.
    fork
      begin
        for (int i = 0; i < 150; i++) rand_req(0);
      end
      begin
        for (int j = 0; j < 150; j++) rand_req(1);
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The block SHALL have parameter MEM_BYTES, default 1024, giving the highest legal address plus one.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 The block SHALL have ports req0 and req1, input, 1 bit each: request valid from port 0 (core LSU) and port 1 (DMA/debug).
REQ-007 The block SHALL have ports addr0 and addr1 (input, ADDR_W), wdata0 and wdata1 (input, DATA_W), we0 and we1 (input, 2 bits) and re0 and re1 (input, 3 bits): the per-port request fields.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: the request is accepted in any cycle where reqN and gntN are both high.
REQ-009 The block SHALL have ports rvalid0 and rvalid1 (output, 1 bit), rdata0 and rdata1 (output, DATA_W) and err0 and err1 (output, 1 bit): the one-cycle response.
REQ-010 The block SHALL have port lock1, input, 1 bit: port 1 keeps ownership across back-to-back accepted requests.
REQ-011 The block SHALL have ports mem_address (output, ADDR_W), mem_data_in (output, DATA_W), mem_we (output, 2 bits), mem_re (output, 3 bits) and mem_data_out (input, DATA_W), driving the data memory.

Function
REQ-012 we encodings SHALL be 0 none, 1 sb, 2 sh, 3 sw; re encodings SHALL be 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu.
REQ-013 The FSM SHALL have three states (IDLE, ISSUE, RESP) with transitions IDLE->ISSUE on accept, ISSUE->RESP always, RESP->ISSUE on accept, and RESP->IDLE otherwise.
REQ-014 Grants SHALL be combinational and asserted only in IDLE or RESP, with at most one gnt high per cycle.
REQ-015 Arbitration SHALL be round-robin: with both ports requesting, the port not served last wins; after reset, port 0 is treated as last served, so port 1 wins the first tie.
REQ-016 While lock1 is high and port 1 was the last served, gnt0 SHALL be held low.
REQ-017 On accept, the block SHALL register the address, write data, we, re and port ID; in ISSUE, mem_* SHALL present those registered values for exactly one cycle.
REQ-018 In ISSUE, rdata SHALL capture mem_data_out; in RESP, rvalidN for the owning port SHALL be high for exactly one cycle with rdataN valid, giving an accept-to-rvalid latency of 2 cycles.
REQ-019 A store SHALL also produce rvalid, with rdata equal to 0.
REQ-020 An error request SHALL be accepted but never issued: mem_we and mem_re stay 0 in ISSUE, and RESP asserts rvalidN together with errN, with rdata equal to 0.
REQ-021 A request SHALL be an error if any of these holds: we and re are both nonzero; re is 6 or 7; addr+size exceeds MEM_BYTES; addr is misaligned (h requires addr[0]=0, w requires addr[1:0]=0).
REQ-022 A request with we=0 and re=0 SHALL be a no-op: it is accepted and answered with rvalid, without err.
REQ-023 Whenever the FSM is not in ISSUE, mem_we and mem_re SHALL be 0.
REQ-024 Peak throughput SHALL be one request per 2 cycles.

Reset
REQ-025 Asserting reset SHALL force IDLE immediately and clear gnt*, rvalid*, err*, rdata*, mem_we, mem_re, mem_address and mem_data_in to 0, and set the round-robin pointer so that port 1 wins the first tie.
REQ-026 A transaction in flight when reset is asserted SHALL be dropped with no response; a store caught in ISSUE SHALL be suppressed because mem_we is cleared asynchronously.
REQ-027 Grants SHALL resume in the first cycle after reset deasserts.

Structure
REQ-028 Package dmem_pkg SHALL hold the we/re encoding constants, the FSM state typedef and an access-size helper function.
REQ-029 Sub-module rr_arb2 SHALL implement 2-way round-robin arbitration with a lock input and a last-served register.

Verification
REQ-030 Port 0 issues sw to address 8 with wdata 0x8000c0fe, then lw from 8: the bench SHALL see rvalid0 2 cycles after each accept, and the lw returns rdata0 = 0x8000c0fe.
REQ-031 After the sw in REQ-030, port 0 issues lb, lh, lbu and lhu to address 8: rdata0 SHALL be 0xfffffffe, 0xffffc0fe, 0x000000fe and 0x0000c0fe respectively.
REQ-032 Both ports request in the same cycle straight out of reset: port 1 SHALL be granted first, port 0 SHALL be granted in the following RESP cycle, and rvalid pulses SHALL never overlap.
REQ-033 Port 0 issues lw to address 10, then port 1 issues sh to address 1023: each SHALL get err with rdata 0, and mem_we and mem_re SHALL stay 0 throughout.
REQ-034 With lock1 high, port 1 issues three back-to-back requests while port 0 requests continuously: gnt0 SHALL stay low until lock1 drops.
REQ-035 Reset is asserted in ISSUE of an sw to address 32 with wdata 0xdeadbeef: a subsequent lw from 32 SHALL return the old value.
